// File: rtl/regfile_bp_clr.sv
// Register file with one synchronous write port and two combinational read ports.
// Write bypass, optional hardwired zero entry, and a clear sequencer that zeroes the array.
module regfile_bp_clr #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] r_addr1,
  input  logic [ADDR_WIDTH-1:0] r_addr2,
  input  logic                  clr_req,
  output logic [DATA_WIDTH-1:0] r_data1,
  output logic [DATA_WIDTH-1:0] r_data2,
  output logic                  ready
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  ready_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_hit;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_wd;

  // An address is live when it maps to storage and is not the hardwired zero entry.
  function automatic logic addr_live(logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_hit = ready && wr_en && !clr_req && addr_live(wr_addr);

  function automatic logic [DATA_WIDTH-1:0] rd(logic [ADDR_WIDTH-1:0] a);
    if (!ready || !addr_live(a)) return '0;
    if ((BYPASS != 0) && wr_hit && (a == wr_addr)) return wr_data;
    return mem[IDX_W'(a)];
  endfunction

  assign r_data1 = rd(r_addr1);
  assign r_data2 = rd(r_addr2);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ready <= ready_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready_n = ready;
    unique case (state)
      CLEAR: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST_C) begin
          state_n = IDLE;
          ready_n = 1'b1;
          cnt_n   = '0;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
          ready_n = 1'b0;
        end
      end
      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
        ready_n = 1'b0;
      end
    endcase
  end

  // Array write port: clear sequencer has priority over the user write.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = '0;
    mem_wd  = '0;
    if (state == CLEAR) begin
      mem_we  = 1'b1;
      mem_idx = IDX_W'(cnt);
    end else if (wr_hit) begin
      mem_we  = 1'b1;
      mem_idx = IDX_W'(wr_addr);
      mem_wd  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

endmodule

// File: doc/regfile_bp_clr.md
Name: regfile_bp_clr

Overview:
- Parametrised successor to the datapath register file: one synchronous write port, two asynchronous read ports.
- Adds a write-enable, same-cycle write-to-read bypass and a selectable hardwired-zero entry.
- Adds a hardware clear sequencer that zeroes every entry after reset or on request.
- Sits between the decode stage (read addresses) and the writeback stage (write port) of the single-cycle core.

Parameters:
- ADDR_WIDTH, 5, width of all address ports.
- DATA_WIDTH, 32, width of each register.
- DEPTH, 32, number of entries; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data; 0 = it returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- r_addr1  input  ADDR_WIDTH  read port 1 address.
- r_addr2  input  ADDR_WIDTH  read port 2 address.
- clr_req  input  1  single-cycle request to zero all entries.
- r_data1  output  DATA_WIDTH  read port 1 data (combinational).
- r_data2  output  DATA_WIDTH  read port 2 data (combinational).
- ready  output  1  high when the file accepts writes and returns valid reads.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - rst asserted forces state CLEAR, clear counter cnt = 0 and ready = 0.
  - r_data1 and r_data2 read 0 while ready = 0.
  - The storage array itself is not reset by rst.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each rising edge writes 0 to entry cnt, then increments cnt.
  - On the edge that clears entry DEPTH-1, go to IDLE and set ready = 1.
  - ready therefore rises DEPTH edges after rst deasserts.
  - wr_en and clr_req are ignored in CLEAR.
- IDLE state:
  - If clr_req = 1, go to CLEAR at the next edge with cnt = 0 and ready = 0.
  - A write in the same cycle as clr_req is dropped (clear wins).
  - Otherwise, if wr_en = 1, store wr_data at wr_addr on the rising edge.
- Write suppression, in any state:
  - wr_addr >= DEPTH: write dropped.
  - ZERO_REG = 1 and wr_addr = 0: write dropped.
- Reads, combinational, zero cycles latency:
  - ready = 0: data = 0.
  - Address >= DEPTH: data = 0.
  - ZERO_REG = 1 and address = 0: data = 0.
  - BYPASS = 1, ready = 1, wr_en = 1, clr_req = 0, address = wr_addr and the write is not suppressed: data = wr_data.
  - Otherwise: data = the stored entry.
  - Both ports are fully independent and may use the same address.
- Counter cnt is ADDR_WIDTH+1 bits wide, so DEPTH = 2**ADDR_WIDTH terminates without wrap-around.
- rst asserted mid-CLEAR or mid-write: state returns to CLEAR with cnt = 0. An in-flight write is lost; the full clear sequence repeats.

Test Plan:
1. Reset release, DEPTH=32 -> ready = 0 for 32 edges, 1 after the 32nd; all 32 reads return 0 without any write.
2. IDLE: write 0xDEADBEEF to addr 5 with r_addr1 = 5, BYPASS=1 -> r_data1 = 0xDEADBEEF in the same cycle; after wr_en drops, r_data1 still = 0xDEADBEEF. With BYPASS=0 -> old value in the write cycle, new value after the edge.
3. Write 0x12345678 to addr 0, ZERO_REG=1 -> r_data1/r_data2 at addr 0 read 0 before and after the edge. With ZERO_REG=0 -> reads 0x12345678 after the edge.
4. Fill addrs 1..31 with their index, then pulse clr_req together with wr_en (addr 3, 0xFFFF) -> write dropped; ready low 32 cycles; all entries then read 0.
5. DEPTH=20, write addr 25 and read addr 25 -> no storage change, reads return 0; addr 19 behaves as a normal register.
6. Assert rst at cnt = 10 during CLEAR -> cnt restarts at 0; ready rises exactly 32 edges after the second rst deassertion.
